// File: rtl/cfg_loader_pkg.sv
// cfg_loader_pkg
// Shared definitions for the configuration memory loader: FSM state
// encoding, default frame sync byte, header length and the order in which
// payload bits are shifted into the tile.
package cfg_loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_SHIFT,
    ST_DRAIN,
    ST_FIN
  } state_t;

  // First byte of every frame unless overridden at the top level.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Header after the sync byte: start address (2 bytes) + bit count (2 bytes).
  localparam int HDR_LEN = 4;

  // Payload bytes are written to the tile least-significant bit first.
  localparam bit PAYLOAD_LSB_FIRST = 1'b1;

  // Number of bits taken from the next payload byte: min(8, bits remaining).
  function automatic logic [3:0] chunk_bits(input logic [15:0] bits_left);
    return (bits_left >= 16'd8) ? 4'd8 : bits_left[3:0];
  endfunction

endpackage

// File: rtl/cfg_bit_serializer.sv
// cfg_bit_serializer
// Turns one payload byte into a run of single-bit tile writes at
// consecutive addresses. All tile-facing outputs are registered.
//
// Ports:
//   clk, reset   configuration clock, asynchronous active-low reset
//   set_addr     load the address counter from addr_in
//   addr_in      frame start address
//   load         latch byte_in; first write strobe appears next cycle
//   byte_in      payload byte
//   nbits        bits to write from byte_in (1..8)
//   step         advance one bit (asserted for every SHIFT cycle)
//   enable       tile write strobe
//   address      tile address, index 0 is the MSB
//   data_in      tile write data
//   last         the strobe currently presented is the final one of the byte
module cfg_bit_serializer
  import cfg_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_addr,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  load,
  input  logic [7:0]            byte_in,
  input  logic [3:0]            nbits,
  input  logic                  step,
  output logic                  enable,
  output logic [0:ADDR_WIDTH-1] address,
  output logic                  data_in,
  output logic                  last
);

  logic [7:0]            shreg;
  logic [2:0]            bit_cnt;
  logic [ADDR_WIDTH-1:0] addr_cnt;

  // bit_cnt holds the number of strobes still to follow the current one.
  assign last    = (bit_cnt == 3'd0);
  assign address = addr_cnt;

  // Address counter: set from the header, then bumped after every strobe.
  // Because the counter is the registered address output, each strobe sees
  // the address of its own bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_cnt <= '0;
    end else if (set_addr) begin
      addr_cnt <= addr_in;
    end else if (step) begin
      addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
    end
  end

  // Shift register and strobe generation. The first bit is driven straight
  // from byte_in on load so the strobe appears in the cycle after the byte
  // is accepted; the remaining bits come out of shreg.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      enable  <= 1'b0;
      data_in <= 1'b0;
    end else if (load) begin
      enable  <= 1'b1;
      data_in <= PAYLOAD_LSB_FIRST ? byte_in[0] : byte_in[7];
      shreg   <= PAYLOAD_LSB_FIRST ? (byte_in >> 1) : (byte_in << 1);
      bit_cnt <= 3'(nbits - 4'd1);
    end else if (step) begin
      if (last) begin
        enable  <= 1'b0;
        data_in <= 1'b0;
      end else begin
        data_in <= PAYLOAD_LSB_FIRST ? shreg[0] : shreg[7];
        shreg   <= PAYLOAD_LSB_FIRST ? (shreg >> 1) : (shreg << 1);
        bit_cnt <= bit_cnt - 3'd1;
      end
    end
  end

endmodule

// File: rtl/cfg_mem_loader.sv
// cfg_mem_loader
// Receives framed configuration bytes on a valid/ready stream and writes the
// payload bit by bit into a CLB tile's configuration memory port.
// Frame: sync, start address (2 bytes LE), bit count N (2 bytes LE),
// ceil(N/8) payload bytes.
//
// Ports:
//   clk, reset          configuration clock, asynchronous active-low reset
//   s_valid/s_ready     byte stream handshake, s_data the byte
//   enable/address/data_in  registered tile configuration write port
//   busy                a frame is in progress
//   done                one-cycle pulse at the end of every frame
//   err_sync            one-cycle pulse for a discarded non-sync byte
//   err_range           one-cycle pulse for a header whose range overflows
module cfg_mem_loader
  import cfg_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 10,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [7:0]            s_data,
  output logic                  enable,
  output logic [0:ADDR_WIDTH-1] address,
  output logic                  data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err_sync,
  output logic                  err_range
);

  localparam int CW = ADDR_WIDTH + 2;
  // 2^ADDR_WIDTH: the first address past the end of the tile.
  localparam logic [CW-1:0] ADDR_SPACE = {2'b01, {ADDR_WIDTH{1'b0}}};

  state_t state, state_nxt;

  logic                  ready_ok;
  logic                  accepting;
  logic                  xfer;
  logic [1:0]            hdr_cnt;
  logic                  hdr_last;
  logic [7:0]            addr_lo, addr_hi, n_lo;
  logic [15:0]           hdr_n;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic                  n_too_big;
  logic [CW-1:0]         range_end;
  logic                  range_bad;
  logic [15:0]           bits_left;
  logic [3:0]            chunk;
  logic                  ser_set_addr, ser_load, ser_step, ser_last;

  // ready_ok keeps s_ready low during reset and lets it rise one clock
  // after release.
  assign accepting = ready_ok && (state == ST_IDLE || state == ST_HDR ||
                                  state == ST_LOAD || state == ST_DRAIN);
  assign s_ready   = accepting;
  assign xfer      = s_valid && accepting;

  assign hdr_last   = (hdr_cnt == 2'(HDR_LEN - 1));
  // The count's high byte is still on s_data when the header decision is made.
  assign hdr_n      = {s_data, n_lo};
  assign start_addr = ADDR_WIDTH'({addr_hi, addr_lo});
  // Counts that do not fit in the CW-bit sum are rejected outright; otherwise
  // the CW-bit sum cannot overflow.
  assign n_too_big  = (hdr_n >> (ADDR_WIDTH + 1)) != 16'd0;
  assign range_end  = {2'b00, start_addr} + CW'(hdr_n);
  assign range_bad  = n_too_big || (range_end > ADDR_SPACE);

  assign chunk = chunk_bits(bits_left);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (xfer && s_data == SYNC_BYTE) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        if (xfer && hdr_last) begin
          if (hdr_n == 16'd0)  state_nxt = ST_FIN;
          else if (range_bad)  state_nxt = ST_DRAIN;
          else                 state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (xfer) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ser_last) state_nxt = (bits_left == 16'd0) ? ST_FIN : ST_LOAD;
      end
      ST_DRAIN: begin
        if (xfer && bits_left <= 16'd8) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output and serializer control decode.
  always_comb begin
    busy         = (state != ST_IDLE);
    done         = (state == ST_FIN);
    ser_set_addr = (state == ST_HDR) && xfer && hdr_last;
    ser_load     = (state == ST_LOAD) && xfer;
    ser_step     = (state == ST_SHIFT);
  end

  // Header capture, remaining-bit counter and error pulses. The same bit
  // counter paces both real loads and the drain of a rejected frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_ok  <= 1'b0;
      hdr_cnt   <= '0;
      addr_lo   <= '0;
      addr_hi   <= '0;
      n_lo      <= '0;
      bits_left <= '0;
      err_sync  <= 1'b0;
      err_range <= 1'b0;
    end else begin
      ready_ok  <= 1'b1;
      err_sync  <= (state == ST_IDLE) && xfer && (s_data != SYNC_BYTE);
      err_range <= (state == ST_HDR) && xfer && hdr_last &&
                   (hdr_n != 16'd0) && range_bad;
      if (state == ST_IDLE) begin
        hdr_cnt <= '0;
      end
      if (state == ST_HDR && xfer) begin
        case (hdr_cnt)
          2'd0:    addr_lo   <= s_data;
          2'd1:    addr_hi   <= s_data;
          2'd2:    n_lo      <= s_data;
          default: bits_left <= hdr_n;
        endcase
        hdr_cnt <= hdr_cnt + 2'd1;
      end
      if ((state == ST_LOAD || state == ST_DRAIN) && xfer) begin
        bits_left <= bits_left - {12'd0, chunk};
      end
    end
  end

  cfg_bit_serializer #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_serializer (
    .clk     (clk),
    .reset   (reset),
    .set_addr(ser_set_addr),
    .addr_in (start_addr),
    .load    (ser_load),
    .byte_in (s_data),
    .nbits   (chunk),
    .step    (ser_step),
    .enable  (enable),
    .address (address),
    .data_in (data_in),
    .last    (ser_last)
  );

endmodule

// File: tb/tb_cfg_mem_loader.sv
// tb_cfg_mem_loader
// Scoreboard bench for cfg_mem_loader. Stimulus pushes the expected tile
// writes and status pulses into queues before sending a frame; a monitor on
// the falling clock edge pops and compares whenever the DUT strobes.
module tb_cfg_mem_loader;

  localparam int AW = 10;

  localparam logic [1:0] EV_DONE  = 2'd0;
  localparam logic [1:0] EV_SYNC  = 2'd1;
  localparam logic [1:0] EV_RANGE = 2'd2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          data;
  } wr_t;

  typedef struct packed {
    logic [1:0] kind;
    logic       after_write;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = 8'h00;
  logic          enable;
  logic [0:AW-1] address;
  logic          data_in;
  logic          busy;
  logic          done;
  logic          err_sync;
  logic          err_range;

  wr_t        wq[$];
  ev_t        eq[$];
  logic [7:0] tx_q[$];

  int n_compared = 0;
  int n_mismatch = 0;

  logic prev_en = 1'b0;
  logic prev_xfer = 1'b0;

  always #5 clk = ~clk;

  cfg_mem_loader #(
    .ADDR_WIDTH(AW),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .enable   (enable),
    .address  (address),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .err_sync (err_sync),
    .err_range(err_range)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Expected writes as a hand-written string of bits in write order.
  task automatic exp_writes(input int start, input string bits);
    for (int i = 0; i < bits.len(); i++) begin
      wr_t w;
      w.addr = AW'(start + i);
      w.data = (bits[i] == "1");
      wq.push_back(w);
    end
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic after_write);
    ev_t e;
    e.kind        = kind;
    e.after_write = after_write;
    eq.push_back(e);
  endtask

  // Sends every byte in tx_q, optionally inserting random s_valid gaps.
  task automatic apply_stimulus(input int max_gap);
    @(posedge clk);
    #1;
    while (tx_q.size() > 0) begin
      logic [7:0] b;
      int         gap;
      bit         sent;
      b   = tx_q.pop_front();
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      s_data  = b;
      s_valid = 1'b1;
      sent    = 1'b0;
      for (int i = 0; i < 200 && !sent; i++) begin
        @(negedge clk);
        if (s_ready) begin
          @(posedge clk);
          #1;
          sent = 1'b1;
        end
      end
      s_valid = 1'b0;
      s_data  = 8'h00;
      if (!sent) check_output("send_timeout", int'(sent), 1);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (wq.size() == 0 && eq.size() == 0) ok = 1'b1;
    end
    check_output("drain_timeout", int'(ok), 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic handle_event(input logic sig, input logic [1:0] kind, input string name);
    ev_t e;
    if (sig) begin
      if (eq.size() == 0) begin
        check_output({name, "_spurious"}, int'(sig), 0);
      end else begin
        e = eq.pop_front();
        check_output({name, "_kind"}, int'(kind), int'(e.kind));
        check_output({name, "_timing"}, e.after_write ? int'(prev_en) : int'(prev_xfer), 1);
      end
    end
  endtask

  // Monitor: compares every tile write and status pulse against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      prev_en   = 1'b0;
      prev_xfer = 1'b0;
    end else begin
      if (enable) begin
        check_output("ready_in_shift", int'(s_ready), 0);
        if (wq.size() == 0) begin
          check_output("spurious_write", int'(enable), 0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check_output("write_addr", int'(address), int'(w.addr));
          check_output("write_data", int'(data_in), int'(w.data));
        end
      end
      handle_event(done, EV_DONE, "done");
      handle_event(err_sync, EV_SYNC, "err_sync");
      handle_event(err_range, EV_RANGE, "err_range");
      prev_en   = enable;
      prev_xfer = s_valid && s_ready;
    end
  end

  initial begin
    bit hit;
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_s_ready", int'(s_ready), 0);
    check_output("rst_enable", int'(enable), 0);
    check_output("rst_address", int'(address), 0);
    check_output("rst_data_in", int'(data_in), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_done", int'(done), 0);
    check_output("rst_err_sync", int'(err_sync), 0);
    check_output("rst_err_range", int'(err_range), 0);
    reset = 1'b1;

    // Ten bits from 0x010, second byte partial.
    exp_writes(10'h010, "1010110111");
    push_ev(EV_DONE, 1'b1);
    tx_q = '{8'hA5, 8'h10, 8'h00, 8'h0A, 8'h00, 8'hB5, 8'h03};
    apply_stimulus(0);
    wait_idle();

    // Two junk bytes, then a one-bit frame.
    push_ev(EV_SYNC, 1'b0);
    push_ev(EV_SYNC, 1'b0);
    exp_writes(10'h020, "1");
    push_ev(EV_DONE, 1'b1);
    tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h20, 8'h00, 8'h01, 8'h00, 8'h01};
    apply_stimulus(0);
    wait_idle();

    // 0x3FC + 8 overruns the tile: drained, no writes.
    push_ev(EV_RANGE, 1'b0);
    push_ev(EV_DONE, 1'b0);
    tx_q = '{8'hA5, 8'hFC, 8'h03, 8'h08, 8'h00, 8'hFF};
    apply_stimulus(0);
    wait_idle();

    // Empty frame.
    push_ev(EV_DONE, 1'b0);
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00};
    apply_stimulus(0);
    wait_idle();

    // Same ten-bit frame with random valid gaps, twice.
    for (int r = 0; r < 2; r++) begin
      exp_writes(10'h010, "1010110111");
      push_ev(EV_DONE, 1'b1);
      tx_q = '{8'hA5, 8'h10, 8'h00, 8'h0A, 8'h00, 8'hB5, 8'h03};
      apply_stimulus(3);
      wait_idle();
    end

    // Reset during the third write of a 0x6B payload at 0x200.
    exp_writes(10'h200, "110");
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h08, 8'h00, 8'h6B};
    apply_stimulus(0);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (enable && address == 10'h202) hit = 1'b1;
    end
    check_output("reset_write3_seen", int'(hit), 1);
    check_output("busy_mid_frame", int'(busy), 1);
    #1;
    reset = 1'b0;
    #1;
    check_output("abort_enable", int'(enable), 0);
    check_output("abort_address", int'(address), 0);
    check_output("abort_data_in", int'(data_in), 0);
    check_output("abort_s_ready", int'(s_ready), 0);
    check_output("abort_busy", int'(busy), 0);
    check_output("abort_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Frame ending exactly at the top of the address space.
    exp_writes(10'h3F8, "11000011");
    push_ev(EV_DONE, 1'b1);
    tx_q = '{8'hA5, 8'hF8, 8'h03, 8'h08, 8'h00, 8'hC3};
    apply_stimulus(0);
    wait_idle();

    check_output("writes_left", wq.size(), 0);
    check_output("events_left", eq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/cfg_mem_loader.md
# cfg_mem_loader

Configuration loader that sits directly upstream of the CLB grid tiles. It accepts a framed byte stream over a valid/ready handshake and serialises the payload into the tile's memory-bank configuration port (`enable`, `address`, `data_in`), one bit per clock, at auto-incrementing addresses. It reports frame completion and header errors to the chip-level configuration controller.

## Interface
- `ADDR_WIDTH`, 10: configuration address width; matches the tile `address` port.
- `SYNC_BYTE`, 8'hA5: required first byte of every frame.
- `clk`  input  1  configuration clock.
- `reset`  input  1  asynchronous, active-low reset.
- `s_valid`  input  1  byte stream valid.
- `s_ready`  output  1  byte stream ready.
- `s_data`  input  8  byte stream data.
- `enable`  output  1  tile config write strobe, registered.
- `address`  output  [0:ADDR_WIDTH-1]  tile config address, registered; index 0 is the MSB.
- `data_in`  output  1  tile config write data, registered.
- `busy`  output  1  high from the first accepted byte until `done`.
- `done`  output  1  one-cycle pulse at the end of a frame.
- `err_sync`  output  1  one-cycle pulse when a non-sync byte is discarded in IDLE.
- `err_range`  output  1  one-cycle pulse when a header is rejected.

## Operation
- Frame format:
  - sync byte;
  - start address, 2 bytes, little-endian, low `ADDR_WIDTH` bits used;
  - bit count N, 2 bytes, little-endian;
  - ceil(N/8) payload bytes, each shifted out LSB first.
- A byte transfers on a clock edge where `s_valid` and `s_ready` are both high.
- States: IDLE, HDR, LOAD, SHIFT, DRAIN, FIN.
- IDLE:
  - `s_ready`=1.
  - A sync byte moves to HDR.
  - Any other byte is discarded and pulses `err_sync`.
- HDR:
  - `s_ready`=1; captures 4 bytes.
  - After the 4th byte:
    - N=0 goes to FIN.
    - start+N > 2^ADDR_WIDTH pulses `err_range` and goes to DRAIN.
    - Otherwise goes to LOAD.
- LOAD:
  - `s_ready`=1.
  - An accepted byte is latched into the shift register; the state moves to SHIFT with k = min(8, bits remaining).
- SHIFT:
  - `s_ready`=0.
  - For k cycles, drive `enable`=1, `data_in`=current bit, `address`=current address.
  - The address increments after each write.
  - After the k-th bit: go to FIN if bits remaining = 0, else go to LOAD.
- DRAIN:
  - `s_ready`=1.
  - Accepts and discards ceil(N/8) bytes with no writes, then goes to FIN.
  - N/range arithmetic uses ADDR_WIDTH+2 bits, so there is no overflow.
- FIN: `done`=1 for one cycle, then IDLE.
  - `done` also pulses after a rejected frame. `err_range` distinguishes the two cases.
- Unused bits of the final partial payload byte (bits k..7) are ignored.
- `enable`=0 in every state except SHIFT.
- Address wrap-around cannot occur, because the range check prevents it.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE and all outputs 0.
  - `s_ready` becomes 1 in the first cycle after reset deassertion.
- Reset mid-frame aborts the frame immediately:
  - no `done` pulse;
  - no further writes;
  - the tile retains any bits already written.
- A payload byte accepted at edge t produces write strobes in cycles t+1 … t+k.
- `s_ready` reasserts in cycle t+k+1, giving a sustained rate of 9 cycles per full byte.
- `done` is high in the cycle after the last write strobe.
- An `s_valid` drop in LOAD/HDR/DRAIN simply stalls the FSM. No timeout.
- In SHIFT, `s_valid`/`s_data` are ignored and the source must hold them.
- `err_sync`/`err_range` are high in the cycle after the offending byte's edge.

## Structure
- Package `cfg_loader_pkg` holds:
  - state enum;
  - `SYNC_BYTE` default;
  - header length constant (4);
  - payload bit order constant.
- One sub-module, `cfg_bit_serializer`:
  - 8-bit shift register, 3-bit bit counter and address counter;
  - load/step inputs, `last` output.
- The FSM, header capture and range check stay in `cfg_mem_loader`.

## Test plan
- Frame A5, 10 00, 0A 00, payload B5 03:
  - 10 writes at addresses 0x010…0x019 with data 1,0,1,0,1,1,0,1,1,1;
  - `done` one cycle after the address-0x019 write;
  - no error pulses.
- Bytes 00 FF then a valid 1-bit frame:
  - `err_sync` pulses twice;
  - the next frame writes 1 bit correctly.
- Header start 0x3FC, N=8:
  - `err_range` pulses;
  - 1 payload byte is drained with no `enable`;
  - `done` pulses.
- Header N=0:
  - no payload is consumed;
  - `done` 1 cycle after the last header byte;
  - `enable` never asserted.
- Random `s_valid` gaps during header and payload:
  - write sequence identical to the gap-free run;
  - `s_ready` is never high in SHIFT.
- Reset asserted during the 3rd write of a frame:
  - all outputs 0 immediately;
  - no `done`;
  - the next frame after release is processed normally.
